// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between multicycle_ctrl and the datapath
//
// Groups the controller's datapath-facing signals.
//   master : controller side. It reads instr/eq/mem_ready and drives every select and strobe.
//   slave  : datapath side, the mirror image of master.
// Signals:
//   instr      instruction register contents
//   eq         ALU zero flag
//   mem_ready  the memory finished the current access this cycle
//   PCWrite, IRWrite, AdrSrc, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ResultSrc,
//   ALUCtrl, ImmSrc, jalmuxSel, retire, illegal   controller outputs
interface multicycle_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]    instr;
  logic                     eq;
  logic                     mem_ready;
  logic                     PCWrite;
  logic                     IRWrite;
  logic                     AdrSrc;
  logic                     RegWrite;
  logic                     MemWrite;
  logic [1:0]               ALUSrcA;
  logic [1:0]               ALUSrcB;
  logic [1:0]               ResultSrc;
  logic [ALUCTRL_WIDTH-1:0] ALUCtrl;
  logic [2:0]               ImmSrc;
  logic                     jalmuxSel;
  logic                     retire;
  logic                     illegal;

  modport master (
    input  instr, eq, mem_ready,
    output PCWrite, IRWrite, AdrSrc, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ALUCtrl, ImmSrc, jalmuxSel, retire, illegal
  );

  modport slave (
    output instr, eq, mem_ready,
    input  PCWrite, IRWrite, AdrSrc, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ALUCtrl, ImmSrc, jalmuxSel, retire, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multi-cycle core
//
// Sequences the shared register file, ALU and unified memory over several
// cycles per instruction. Outputs are a Moore decode of the state, qualified by
// instr fields, eq and mem_ready where needed. No strobe is registered, so
// reset removes every strobe in the same cycle it is asserted.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; returns to FETCH and holds all outputs at 0
//   bus  multicycle_ctrl_if.master carrying instr/eq/mem_ready in and all selects and strobes out
module multicycle_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  localparam logic [ALUCTRL_WIDTH-1:0] alu_add = ALUCTRL_WIDTH'(3'b000);
  localparam logic [ALUCTRL_WIDTH-1:0] alu_sub = ALUCTRL_WIDTH'(3'b001);
  localparam logic [ALUCTRL_WIDTH-1:0] alu_and = ALUCTRL_WIDTH'(3'b010);
  localparam logic [ALUCTRL_WIDTH-1:0] alu_or  = ALUCTRL_WIDTH'(3'b011);
  localparam logic [ALUCTRL_WIDTH-1:0] alu_slt = ALUCTRL_WIDTH'(3'b101);

  localparam logic [2:0] imm_i = 3'b000;
  localparam logic [2:0] imm_s = 3'b001;
  localparam logic [2:0] imm_b = 3'b010;
  localparam logic [2:0] imm_j = 3'b011;
  localparam logic [2:0] imm_u = 3'b100;

  localparam logic [6:0] op_lw   = 7'b0000011;
  localparam logic [6:0] op_sw   = 7'b0100011;
  localparam logic [6:0] op_r    = 7'b0110011;
  localparam logic [6:0] op_i    = 7'b0010011;
  localparam logic [6:0] op_br   = 7'b1100011;
  localparam logic [6:0] op_jal  = 7'b1101111;
  localparam logic [6:0] op_jalr = 7'b1100111;
  localparam logic [6:0] op_lui  = 7'b0110111;

  typedef enum logic [3:0] {
    st_fetch, st_decode, st_memadr, st_memrd, st_memwb, st_memwr,
    st_execr, st_execi, st_aluwb, st_branch, st_jal, st_jalr,
    st_jalrwb, st_lui, st_trap
  } state_t;

  state_t state, state_n;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7b5 = bus.instr[30];

  // Register numbers and immediate bits belong to the datapath, not to this FSM.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[DATA_WIDTH-1:31], bus.instr[29:15], bus.instr[11:7]};

  // ALU function for register/immediate arithmetic. alu_ok low marks a funct3
  // the core does not implement; the FSM traps on it.
  logic                     alu_ok;
  logic                     alu_sub_req;
  logic [ALUCTRL_WIDTH-1:0] alu_fn;

  always_comb begin
    alu_ok      = 1'b1;
    alu_fn      = alu_add;
    alu_sub_req = (state == st_execr) && funct7b5;   // immediate forms never subtract
    case (funct3)
      3'b000:  alu_fn = alu_sub_req ? alu_sub : alu_add;
      3'b111:  alu_fn = alu_and;
      3'b110:  alu_fn = alu_or;
      3'b010:  alu_fn = alu_slt;
      default: alu_ok = 1'b0;
    endcase
  end

  // Immediate format selected in DECODE so the branch/jal target can be precomputed.
  logic [2:0] imm_by_op;

  always_comb begin
    imm_by_op = imm_i;
    case (opcode)
      op_sw:   imm_by_op = imm_s;
      op_br:   imm_by_op = imm_b;
      op_jal:  imm_by_op = imm_j;
      op_lui:  imm_by_op = imm_u;
      default: imm_by_op = imm_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= st_fetch;
    end else begin
      state <= state_n;
    end
  end

  logic                     pc_write;
  logic                     ir_write;
  logic                     adr_src;
  logic                     reg_write;
  logic                     mem_write;
  logic [1:0]               alu_src_a;
  logic [1:0]               alu_src_b;
  logic [1:0]               result_src;
  logic [ALUCTRL_WIDTH-1:0] alu_ctrl;
  logic [2:0]               imm_src;
  logic                     jalmux_sel;
  logic                     retire_o;
  logic                     illegal_o;

  always_comb begin
    state_n    = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = alu_add;
    imm_src    = imm_i;
    jalmux_sel = 1'b0;
    retire_o   = 1'b0;
    illegal_o  = 1'b0;

    // While reset is held every output stays at 0 regardless of state.
    if (!rst) begin
      case (state)
        st_fetch: begin
          // PC+4 computed on the ALU and written straight back to PC.
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          pc_write   = bus.mem_ready;
          ir_write   = bus.mem_ready;
          if (bus.mem_ready) state_n = st_decode;
        end

        st_decode: begin
          // oldPC + imm lands in ALUOut for BRANCH/JAL to use next cycle.
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = imm_by_op;
          case (opcode)
            op_lw, op_sw: state_n = st_memadr;
            op_r:         state_n = st_execr;
            op_i:         state_n = st_execi;
            op_br:        state_n = st_branch;
            op_jal:       state_n = st_jal;
            op_jalr:      state_n = st_jalr;
            op_lui:       state_n = st_lui;
            default:      state_n = st_trap;
          endcase
        end

        st_execr: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b00;
          alu_ctrl  = alu_fn;
          state_n   = alu_ok ? st_aluwb : st_trap;
        end

        st_execi: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = imm_i;
          alu_ctrl  = alu_fn;
          state_n   = alu_ok ? st_aluwb : st_trap;
        end

        st_lui: begin
          // rs1 is forced to x0 by the decoder, so x0 + U-imm is the result.
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = imm_u;
          state_n   = st_aluwb;
        end

        st_aluwb: begin
          result_src = 2'b00;
          reg_write  = 1'b1;
          retire_o   = 1'b1;
          state_n    = st_fetch;
        end

        st_memadr: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (opcode == op_sw) ? imm_s : imm_i;
          state_n   = (opcode == op_sw) ? st_memwr : st_memrd;
        end

        st_memrd: begin
          adr_src = 1'b1;
          if (bus.mem_ready) state_n = st_memwb;
        end

        st_memwb: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          retire_o   = 1'b1;
          state_n    = st_fetch;
        end

        st_memwr: begin
          // Strobe held for the whole wait; the store completes on mem_ready.
          adr_src   = 1'b1;
          mem_write = 1'b1;
          if (bus.mem_ready) begin
            retire_o = 1'b1;
            state_n  = st_fetch;
          end
        end

        st_branch: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b00;
          alu_ctrl   = alu_sub;
          result_src = 2'b00;
          state_n    = st_fetch;
          case (funct3)
            3'b000: begin
              pc_write = bus.eq;
              retire_o = 1'b1;
            end
            3'b001: begin
              pc_write = !bus.eq;
              retire_o = 1'b1;
            end
            default: state_n = st_trap;
          endcase
        end

        st_jal: begin
          // Target was precomputed in DECODE; rd gets oldPC+4 via jalmuxSel.
          result_src = 2'b00;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          jalmux_sel = 1'b1;
          retire_o   = 1'b1;
          state_n    = st_fetch;
        end

        st_jalr: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = imm_i;
          state_n   = st_jalrwb;
        end

        st_jalrwb: begin
          result_src = 2'b00;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          jalmux_sel = 1'b1;
          retire_o   = 1'b1;
          state_n    = st_fetch;
        end

        st_trap: begin
          illegal_o = 1'b1;
          state_n   = st_trap;
        end

        default: state_n = st_trap;
      endcase
    end
  end

  assign bus.PCWrite   = pc_write;
  assign bus.IRWrite   = ir_write;
  assign bus.AdrSrc    = adr_src;
  assign bus.RegWrite  = reg_write;
  assign bus.MemWrite  = mem_write;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ResultSrc = result_src;
  assign bus.ALUCtrl   = alu_ctrl;
  assign bus.ImmSrc    = imm_src;
  assign bus.jalmuxSel = jalmux_sel;
  assign bus.retire    = retire_o;
  assign bus.illegal   = illegal_o;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle build of the core. It sequences the shared register file, ALU and unified instruction/data memory over several cycles per instruction. It drives every datapath select and write-enable (RegWrite, ALUsrc, ResultSrc, MemWrite, ALUCtrl, jalmuxSel, PC/IR enables). It waits on a memory-ready handshake and flags illegal opcodes.

Parameters:
DATA_WIDTH, 32, instruction width.
ALUCTRL_WIDTH, 3, width of ALUCtrl.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
instr  in  DATA_WIDTH  instruction register contents; valid from DECODE onward.
eq  in  1  ALU Zero flag.
mem_ready  in  1  memory has completed the current read/write this cycle.
PCWrite  out  1  load PC.
IRWrite  out  1  load instruction register (and oldPC).
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut register.
RegWrite  out  1  register-file write enable.
MemWrite  out  1  data memory write strobe.
ALUSrcA  out  2  00=PC, 01=oldPC, 10=rs1.
ALUSrcB  out  2  00=rs2, 01=ImmOp, 10=constant 4.
ResultSrc  out  2  00=ALUOut register, 01=ReadData, 10=ALU result (combinational).
ALUCtrl  out  ALUCTRL_WIDTH  000 add, 001 sub, 010 and, 011 or, 101 slt.
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
jalmuxSel  out  1  register write data = oldPC+4.
retire  out  1  one-cycle pulse in the final cycle of each instruction.
illegal  out  1  sticky illegal-instruction flag.

Behaviour:
- Reset (async, rst=1): state=FETCH. illegal=0. All enables (PCWrite, IRWrite, RegWrite, MemWrite, retire) = 0. All selects = 0.
- Outputs are a Moore decode of state, plus instr fields and eq where noted. Write strobes are never registered.
- Decoding uses opcode instr[6:0], funct3 instr[14:12] and funct7b5 instr[30].
- Supported instructions: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq/bne 1100011, jal 1101111, jalr 1100111, lui 0110111.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUCtrl=add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0. Goes to DECODE on mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (precomputes branch/jal target into ALUOut). ImmSrc is set from opcode. Next state by opcode:
  - lw/sw → MEMADR.
  - R → EXECR.
  - I-ALU → EXECI.
  - branch → BRANCH.
  - jal → JAL.
  - jalr → JALR.
  - lui → LUI.
  - anything else → TRAP.
- EXECR: ALUSrcA=10, ALUSrcB=00. Then ALUWB.
  - funct3 000: sub if funct7b5, else add.
  - 111: and. 110: or. 010: slt.
  - Other funct3 → TRAP.
- EXECI: same as EXECR with ALUSrcB=01, ImmSrc=I, and funct7b5 ignored (never sub). Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Then FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc = I for lw, S for sw. Then MEMRD (lw) or MEMWR (sw).
- MEMRD: AdrSrc=1. Holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Then FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Holds while mem_ready=0.
  - MemWrite stays asserted through the hold.
  - On mem_ready: retire=1, go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = eq for funct3 000, !eq for 001. Other funct3 → TRAP with PCWrite=0. retire=1. Then FETCH.
- JAL: ResultSrc=00, PCWrite=1, RegWrite=1, jalmuxSel=1, retire=1. Then FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add (target into ALUOut). Then JALRWB.
- JALRWB: ResultSrc=00, PCWrite=1, RegWrite=1, jalmuxSel=1, retire=1. Then FETCH.
- LUI: ImmSrc=U, ALUSrcB=01, ALUSrcA=10, ALUCtrl=add. This relies on the decoder forcing rs1=x0. Then ALUWB.
- TRAP: illegal=1. All enables 0. Absorbing until rst.
- Latency in cycles, excluding memory wait states:
  - R/I/lui: 4.
  - lw: 5.
  - sw: 4.
  - branch: 3.
  - jal: 3.
  - jalr: 4.
- Each extra cycle of mem_ready=0 adds exactly one cycle.
- Reset mid-instruction: immediate return to FETCH. Any in-progress MemWrite/RegWrite is dropped in the same cycle. No retire.
- Exactly one retire pulse per completed instruction. retire never asserts in FETCH, DECODE or TRAP.

Test Plan:
- Reset, then instr=0x002081B3 (add x3,x1,x2) with mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB. ALUCtrl=000 in EXECR. RegWrite=1 and retire=1 only in cycle 4.
- instr=0x40208133 (sub) and 0x0020A1B3 (slt) → ALUCtrl 001 and 101 in EXECR. Then 0x00A00093 (addi) with funct7b5 bit forced 1 → ALUCtrl still 000.
- instr=0x00402283 (lw) with mem_ready low 2 cycles in MEMRD → 7-cycle instruction. AdrSrc=1 through the wait. ResultSrc=01 with RegWrite in MEMWB.
- instr=0x00000463 (beq x0,x0,+8) with eq=1 → PCWrite=1 in cycle 3. Then 0x00001463 (bne) with eq=1 → PCWrite=0. Both retire.
- instr=0x008000EF (jal) → 3 cycles. Final cycle has PCWrite=RegWrite=jalmuxSel=1.
- instr=0x00000000 → TRAP, illegal=1 and stays 1. Then assert rst mid-MEMWR (sw 0x0050A223, mem_ready=0) → MemWrite drops to 0 in the same cycle, state=FETCH, illegal=0.
